// File: rtl/uart_bridge_pkg.sv
// Shared opcodes, status codes, controller state type and timeout helper
// for the UART-to-APB bridge.
package uart_bridge_pkg;

    localparam logic [7:0] OPC_WRITE = 8'h57;
    localparam logic [7:0] OPC_READ  = 8'h52;
    localparam logic [7:0] STS_OK    = 8'h00;
    localparam logic [7:0] STS_ERR   = 8'h01;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        WDATA,
        ISSUE,
        WAIT_RSP,
        SEND
    } ctrl_state_t;

    // One character time is 10 bit times (start + 8 data + stop).
    function automatic int unsigned timeout_cycles(input int unsigned clk_freq,
                                                   input int unsigned baud,
                                                   input int unsigned n_bytes);
        return n_bytes * 10 * (clk_freq / baud);
    endfunction

endpackage

// File: rtl/uart_byte_timer.sv
// Loadable down-counter used as the inter-byte timeout; holds at zero and
// flags expiry there.
module uart_byte_timer #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             en,
    input  logic [WIDTH-1:0] load_value,
    output logic             expired
);

    logic [WIDTH-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (en && count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign expired = (count == '0);

endmodule

// File: rtl/uart_cmd_ctrl.sv
// Frame-level controller: parses UART read/write frames into APB commands and
// streams the status byte plus any read data back to the transmitter.
module uart_cmd_ctrl
    import uart_bridge_pkg::*;
#(
    parameter int unsigned CLK_FREQ      = 100000000,
    parameter int unsigned BAUD          = 115200,
    parameter int unsigned TIMEOUT_BYTES = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  rx_data,
    input  logic        rx_data_valid,
    output logic        cmd_valid,
    input  logic        cmd_ready,
    output logic        cmd_write,
    output logic [31:0] cmd_addr,
    output logic [31:0] cmd_wdata,
    input  logic        rsp_valid,
    input  logic [31:0] rsp_rdata,
    input  logic        rsp_error,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        frame_error,
    output logic        busy
);

    localparam int unsigned TIMEOUT_CYCLES = timeout_cycles(CLK_FREQ, BAUD, TIMEOUT_BYTES);
    localparam int unsigned TW             = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TIMER_LOAD   = TW'(TIMEOUT_CYCLES);

    ctrl_state_t state;
    logic [1:0]  byte_cnt;
    logic [2:0]  tx_rem;
    logic [31:0] rdata_q;

    logic rx_opcode;
    logic timer_en;
    logic timer_load;
    logic timer_expired;

    assign rx_opcode  = (rx_data == OPC_WRITE) || (rx_data == OPC_READ);
    assign timer_en   = (state == ADDR) || (state == WDATA);
    // Reload on entry to ADDR and on every byte accepted while collecting fields.
    assign timer_load = rx_data_valid && (((state == IDLE) && rx_opcode) || timer_en);

    uart_byte_timer #(
        .WIDTH (TW)
    ) u_byte_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (timer_load),
        .en         (timer_en),
        .load_value (TIMER_LOAD),
        .expired    (timer_expired)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            byte_cnt    <= 2'd0;
            tx_rem      <= 3'd0;
            rdata_q     <= 32'h0;
            cmd_valid   <= 1'b0;
            cmd_write   <= 1'b0;
            cmd_addr    <= 32'h0;
            cmd_wdata   <= 32'h0;
            tx_valid    <= 1'b0;
            tx_data     <= 8'h00;
            frame_error <= 1'b0;
            busy        <= 1'b0;
        end else begin
            frame_error <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (rx_data_valid) begin
                        if (rx_opcode) begin
                            cmd_write <= (rx_data == OPC_WRITE);
                            byte_cnt  <= 2'd0;
                            busy      <= 1'b1;
                            state     <= ADDR;
                        end else begin
                            frame_error <= 1'b1;
                        end
                    end
                end
                ADDR: begin
                    if (rx_data_valid) begin
                        cmd_addr <= {cmd_addr[23:0], rx_data};
                        byte_cnt <= byte_cnt + 2'd1;
                        if (byte_cnt == 2'd3) begin
                            if (cmd_write) begin
                                state <= WDATA;
                            end else begin
                                cmd_wdata <= 32'h0;
                                cmd_valid <= 1'b1;
                                state     <= ISSUE;
                            end
                        end
                    end else if (timer_expired) begin
                        frame_error <= 1'b1;
                        byte_cnt    <= 2'd0;
                        cmd_addr    <= 32'h0;
                        cmd_wdata   <= 32'h0;
                        busy        <= 1'b0;
                        state       <= IDLE;
                    end
                end
                WDATA: begin
                    if (rx_data_valid) begin
                        cmd_wdata <= {cmd_wdata[23:0], rx_data};
                        byte_cnt  <= byte_cnt + 2'd1;
                        if (byte_cnt == 2'd3) begin
                            cmd_valid <= 1'b1;
                            state     <= ISSUE;
                        end
                    end else if (timer_expired) begin
                        frame_error <= 1'b1;
                        byte_cnt    <= 2'd0;
                        cmd_addr    <= 32'h0;
                        cmd_wdata   <= 32'h0;
                        busy        <= 1'b0;
                        state       <= IDLE;
                    end
                end
                ISSUE: begin
                    frame_error <= rx_data_valid;
                    if (cmd_ready) begin
                        cmd_valid <= 1'b0;
                        state     <= WAIT_RSP;
                    end
                end
                WAIT_RSP: begin
                    frame_error <= rx_data_valid;
                    if (rsp_valid) begin
                        rdata_q  <= rsp_rdata;
                        tx_data  <= rsp_error ? STS_ERR : STS_OK;
                        // Only a successful read carries data bytes after the status.
                        tx_rem   <= (!cmd_write && !rsp_error) ? 3'd4 : 3'd0;
                        tx_valid <= 1'b1;
                        state    <= SEND;
                    end
                end
                SEND: begin
                    frame_error <= rx_data_valid;
                    if (tx_ready) begin
                        if (tx_rem == 3'd0) begin
                            tx_valid <= 1'b0;
                            busy     <= 1'b0;
                            state    <= IDLE;
                        end else begin
                            tx_data <= rdata_q[31:24];
                            rdata_q <= {rdata_q[23:0], 8'h00};
                            tx_rem  <= tx_rem - 3'd1;
                        end
                    end
                end
                default: begin
                    cmd_valid <= 1'b0;
                    tx_valid  <= 1'b0;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Randomised bench for uart_cmd_ctrl: frames are built as byte lists and the
// expected command and response byte streams are derived from the frame rules.
module tb_uart_cmd_ctrl;

    localparam int unsigned CLK_FREQ      = 1000;
    localparam int unsigned BAUD          = 500;
    localparam int unsigned TIMEOUT_BYTES = 4;
    localparam int unsigned T_CYC         = TIMEOUT_BYTES * 10 * (CLK_FREQ / BAUD);

    logic        clk;
    logic        rst_n;
    logic [7:0]  rx_data;
    logic        rx_data_valid;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [31:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_error;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        frame_error;
    logic        busy;

    uart_cmd_ctrl #(
        .CLK_FREQ      (CLK_FREQ),
        .BAUD          (BAUD),
        .TIMEOUT_BYTES (TIMEOUT_BYTES)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .rx_data       (rx_data),
        .rx_data_valid (rx_data_valid),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_write     (cmd_write),
        .cmd_addr      (cmd_addr),
        .cmd_wdata     (cmd_wdata),
        .rsp_valid     (rsp_valid),
        .rsp_rdata     (rsp_rdata),
        .rsp_error     (rsp_error),
        .tx_data       (tx_data),
        .tx_valid      (tx_valid),
        .tx_ready      (tx_ready),
        .frame_error   (frame_error),
        .busy          (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [64:0] cmd_q[$];
    logic [7:0]  tx_q[$];
    int          fe_seen = 0;
    int          cr_delay = 0;
    bit          tx_rand = 1'b0;
    logic        prev_cv = 1'b0;
    logic        prev_took = 1'b0;
    logic [64:0] prev_payload = '0;
    wire  [64:0] payload = {cmd_write, cmd_addr, cmd_wdata};

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock: observe what the last edge produced, then drive the next inputs.
    task automatic tick(input logic rv = 1'b0, input logic [7:0] rd = 8'h00,
                        input logic sv = 1'b0, input logic [31:0] srd = 32'h0,
                        input logic se = 1'b0);
        @(negedge clk);
        if (frame_error) fe_seen++;
        if (prev_took) check_eq("cmd_valid_drop", {31'b0, cmd_valid}, 32'd0);
        else if (prev_cv && cmd_valid)
            check_eq("cmd_stable", {31'b0, payload == prev_payload}, 32'd1);
        rx_data_valid = rv;
        rx_data       = rd;
        rsp_valid     = sv;
        rsp_rdata     = srd;
        rsp_error     = se;
        if (cmd_valid && cr_delay > 0) begin
            cmd_ready = 1'b0;
            cr_delay--;
        end else begin
            cmd_ready = cmd_valid ? 1'b1 : 1'($urandom_range(0, 1));
        end
        tx_ready  = tx_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        prev_took = cmd_valid && cmd_ready;
        if (prev_took) cmd_q.push_back(payload);
        prev_cv      = cmd_valid;
        prev_payload = payload;
        if (tx_valid && tx_ready) tx_q.push_back(tx_data);
    endtask

    task automatic run_txn(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [31:0] rdata, input bit err, input bit junk);
        logic [7:0] frame[$];
        logic [7:0] exp_tx[$];
        int fe0;
        int n;
        frame.push_back(wr ? 8'h57 : 8'h52);
        for (int i = 3; i >= 0; i--) frame.push_back(addr[8*i +: 8]);
        if (wr) for (int i = 3; i >= 0; i--) frame.push_back(wdata[8*i +: 8]);
        exp_tx.push_back(err ? 8'h01 : 8'h00);
        if (!wr && !err) for (int i = 3; i >= 0; i--) exp_tx.push_back(rdata[8*i +: 8]);

        cmd_q.delete();
        tx_q.delete();
        fe0 = fe_seen;
        // A stray response while idle must not produce any output.
        if ($urandom_range(0, 1) == 1) tick(1'b0, 8'h00, 1'b1, $urandom, 1'b1);
        foreach (frame[i]) begin
            repeat ($urandom_range(0, 3)) tick();
            tick(1'b1, frame[i]);
        end
        tick();
        check_eq("cmd_latency", {31'b0, cmd_valid}, 32'd1);
        n = 0;
        while (cmd_q.size() == 0 && n < 40) begin
            tick();
            n++;
        end
        check_eq("cmd_count", cmd_q.size(), 32'd1);
        if (cmd_q.size() > 0) begin
            check_eq("cmd_write", {31'b0, cmd_q[0][64]}, {31'b0, wr});
            check_eq("cmd_addr", cmd_q[0][63:32], addr);
            check_eq("cmd_wdata", cmd_q[0][31:0], wr ? wdata : 32'h0);
        end
        repeat ($urandom_range(0, 4)) tick();
        if (junk) begin
            tick(1'b1, 8'($urandom));
            tick();
            check_eq("junk_frame_error", fe_seen - fe0, 32'd1);
        end
        tick(1'b0, 8'h00, 1'b1, rdata, err);
        tick();
        check_eq("tx_latency", {31'b0, tx_valid}, 32'd1);
        n = 0;
        while (busy && n < 100) begin
            tick();
            n++;
        end
        check_eq("busy_done", {31'b0, busy}, 32'd0);
        check_eq("tx_count", tx_q.size(), exp_tx.size());
        foreach (exp_tx[i])
            if (i < tx_q.size()) check_eq($sformatf("tx_byte%0d", i), {24'b0, tx_q[i]}, {24'b0, exp_tx[i]});
        check_eq("txn_frame_errors", fe_seen - fe0, junk ? 32'd1 : 32'd0);
    endtask

    initial begin
        int fe0;
        rst_n         = 1'b0;
        rx_data       = 8'h00;
        rx_data_valid = 1'b0;
        cmd_ready     = 1'b0;
        rsp_valid     = 1'b0;
        rsp_rdata     = 32'h0;
        rsp_error     = 1'b0;
        tx_ready      = 1'b0;
        #12;
        check_eq("rst_cmd_valid", {31'b0, cmd_valid}, 32'd0);
        check_eq("rst_cmd_write", {31'b0, cmd_write}, 32'd0);
        check_eq("rst_cmd_addr", cmd_addr, 32'h0);
        check_eq("rst_cmd_wdata", cmd_wdata, 32'h0);
        check_eq("rst_tx_valid", {31'b0, tx_valid}, 32'd0);
        check_eq("rst_tx_data", {24'b0, tx_data}, 32'h0);
        check_eq("rst_frame_error", {31'b0, frame_error}, 32'd0);
        check_eq("rst_busy", {31'b0, busy}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Directed write, then read with delayed ready and random tx back-pressure.
        run_txn(1'b1, 32'h0000_1004, 32'hDEAD_BEEF, 32'h0, 1'b0, 1'b0);
        cr_delay = 5;
        tx_rand  = 1'b1;
        run_txn(1'b0, 32'h0000_0020, 32'h0, 32'h1234_5678, 1'b0, 1'b0);
        run_txn(1'b0, 32'h0000_0040, 32'h0, 32'hCAFE_F00D, 1'b1, 1'b0);
        run_txn(1'b0, 32'h0000_0044, 32'h0, 32'h0BAD_CAFE, 1'b0, 1'b0);

        // Partial read frame then silence.
        fe0 = fe_seen;
        cmd_q.delete();
        tick(1'b1, 8'h52);
        tick(1'b1, 8'h00);
        tick(1'b1, 8'h00);
        repeat (T_CYC) tick();
        check_eq("to_not_early", {31'b0, busy}, 32'd1);
        check_eq("to_no_early_fe", fe_seen - fe0, 32'd0);
        repeat (3) tick();
        check_eq("to_frame_error", fe_seen - fe0, 32'd1);
        check_eq("to_busy_clear", {31'b0, busy}, 32'd0);
        repeat (T_CYC) tick();
        check_eq("to_single_pulse", fe_seen - fe0, 32'd1);
        check_eq("to_no_cmd", cmd_q.size(), 32'd0);
        run_txn(1'b0, 32'hA5A5_0008, 32'h0, 32'h8765_4321, 1'b0, 1'b0);

        // Junk opcode in IDLE, then junk byte while awaiting the response.
        fe0 = fe_seen;
        tick(1'b1, 8'hAA);
        tick();
        check_eq("idle_junk_fe", fe_seen - fe0, 32'd1);
        check_eq("idle_junk_busy", {31'b0, busy}, 32'd0);
        run_txn(1'b0, 32'h0000_0100, 32'h0, 32'h0102_0304, 1'b0, 1'b1);

        // Reset in WDATA after the first data byte.
        cmd_q.delete();
        tick(1'b1, 8'h57);
        for (int i = 0; i < 4; i++) tick(1'b1, 8'h11);
        tick(1'b1, 8'h99);
        tick();
        rst_n = 1'b0;
        #1;
        check_eq("mid_rst_busy", {31'b0, busy}, 32'd0);
        check_eq("mid_rst_addr", cmd_addr, 32'h0);
        check_eq("mid_rst_wdata", cmd_wdata, 32'h0);
        check_eq("mid_rst_write", {31'b0, cmd_write}, 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        run_txn(1'b1, 32'h2000_0010, 32'h5555_AAAA, 32'h0, 1'b0, 1'b0);

        for (int k = 0; k < 20; k++) begin
            cr_delay = $urandom_range(0, 3);
            tx_rand  = 1'($urandom_range(0, 1));
            run_txn(1'($urandom_range(0, 1)), $urandom, $urandom, $urandom,
                    $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
